cpu_debug_ctrl: RTL and testbench

CPU_DEBUG_CTRL -- requirements
Module: cpu_debug_ctrl

---
 rtl/cpu_debug_ctrl.sv | 253 +++++++++++++++++++++++++
 tb/tb_cpu_debug_ctrl.sv | 329 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cpu_debug_ctrl.sv
// -----------------------------------------------------------------------------
// cpu_debug_ctrl
//
// Front-panel debug controller for a small CPU. It debounces three push
// buttons and drives the CPU clock in one of three ways: held low (HALT),
// free-running from a divider (RUN), or a single full clock period (STEP).
// It also counts CPU clock ticks and shows one of three pages of state on
// four 7-segment digits.
//
// Ports
//   clk      in   system clock, all state on the rising edge
//   rst_n    in   asynchronous active-low reset
//   btn[2:0] in   raw active-low buttons: [0] step, [1] run/halt, [2] page
//   pc       in   CPU program counter   (ADDR_WIDTH)
//   sp       in   CPU stack pointer     (ADDR_WIDTH)
//   cpu_out  in   CPU output register   (DATA_WIDTH, at least 16)
//   cpu_clk  out  registered clock to the CPU and memory
//   led[9:0] out  {run, step, page[1:0], cpu_clk, cpu_out[4:0]}
//   hex[27:0]out  four 7-segment digits, [27:21] leftmost, active-low
//                 segments ordered {g,f,e,d,c,b,a}
//
// Display pages
//   0: sp tens, sp ones, pc tens, pc ones (decimal, modulo 100)
//   1: cpu_out[15:0] in hexadecimal
//   2: tick_cnt[15:0] in hexadecimal
// -----------------------------------------------------------------------------
module cpu_debug_ctrl #(
  parameter int DIVISOR    = 50_000_000,
  parameter int DEBOUNCE   = 500_000,
  parameter int ADDR_WIDTH = 6,
  parameter int DATA_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [2:0]            btn,
  input  logic [ADDR_WIDTH-1:0] pc,
  input  logic [ADDR_WIDTH-1:0] sp,
  input  logic [DATA_WIDTH-1:0] cpu_out,
  output logic                  cpu_clk,
  output logic [9:0]            led,
  output logic [27:0]           hex
);

  localparam int HALF  = DIVISOR / 2;
  localparam int DIV_W = (DIVISOR > 1) ? $clog2(DIVISOR) : 1;
  localparam int DB_W  = (DEBOUNCE > 1) ? $clog2(DEBOUNCE) : 1;

  typedef enum logic [1:0] {
    HALT,
    RUN,
    STEP_HI,
    STEP_LO
  } state_t;

  // 7-segment encoding shared by every digit, active-low, {g,f,e,d,c,b,a}.
  function automatic logic [6:0] ssd_seg(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'h0: s = 7'h40;
      4'h1: s = 7'h79;
      4'h2: s = 7'h24;
      4'h3: s = 7'h30;
      4'h4: s = 7'h19;
      4'h5: s = 7'h12;
      4'h6: s = 7'h02;
      4'h7: s = 7'h78;
      4'h8: s = 7'h00;
      4'h9: s = 7'h10;
      4'hA: s = 7'h08;
      4'hB: s = 7'h03;
      4'hC: s = 7'h46;
      4'hD: s = 7'h21;
      4'hE: s = 7'h06;
      default: s = 7'h0E;
    endcase
    return s;
  endfunction

  // ---------------------------------------------------------------------------
  // Button synchronisers and debouncers
  // ---------------------------------------------------------------------------
  logic [2:0]      sync1;
  logic [2:0]      sync2;
  logic [2:0]      db_level;    // accepted (debounced) level, 1 = released
  logic [2:0]      db_level_d;
  logic [DB_W-1:0] db_cnt [3];  // consecutive samples differing from db_level
  logic [2:0]      press;       // one-clk pulse on accepted press

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1      <= '1;
      sync2      <= '1;
      db_level   <= '1;
      db_level_d <= '1;
      // NOTE: this array is a handful of flops, not a RAM, so it is reset
      // with everything else; a real memory array would be left unreset.
      for (int i = 0; i < 3; i++) db_cnt[i] <= '0;
    end else begin
      // NOTE: non-blocking assignments make each flop sample the value from
      // before the edge, so sync1 -> sync2 really is two stages.
      sync1      <= btn;
      sync2      <= sync1;
      db_level_d <= db_level;
      for (int i = 0; i < 3; i++) begin
        if (sync2[i] == db_level[i]) begin
          db_cnt[i] <= '0;
        end else if (db_cnt[i] == DB_W'(DEBOUNCE - 1)) begin
          // DEBOUNCE consecutive samples at the new level: accept it.
          db_level[i] <= sync2[i];
          db_cnt[i]   <= '0;
        end else begin
          db_cnt[i] <= db_cnt[i] + DB_W'(1);
        end
      end
    end
  end

  // Buttons are active-low, so a press is an accepted 1 -> 0 transition.
  assign press = db_level_d & ~db_level;

  // ---------------------------------------------------------------------------
  // CPU clock FSM
  // ---------------------------------------------------------------------------
  state_t          state;
  state_t          state_n;
  logic [DIV_W-1:0] div_cnt;
  logic [DIV_W-1:0] div_cnt_n;
  logic             cpu_clk_n;
  logic             half_done;
  logic [15:0]      tick_cnt;

  assign half_done = (div_cnt == DIV_W'(HALF - 1));

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can
    // leave one unassigned and infer a latch.
    state_n   = state;
    div_cnt_n = div_cnt;
    cpu_clk_n = cpu_clk;
    case (state)
      HALT: begin
        cpu_clk_n = 1'b0;
        div_cnt_n = '0;
        // run/halt wins over step when both are accepted together
        if (press[1]) begin
          state_n = RUN;
        end else if (press[0]) begin
          state_n   = STEP_HI;
          cpu_clk_n = 1'b1;
        end
      end
      RUN: begin
        if (press[1]) begin
          state_n   = HALT;
          cpu_clk_n = 1'b0;
          div_cnt_n = '0;
        end else begin
          // Low for counts 0..HALF-1, high for HALF..DIVISOR-1. Setting the
          // level explicitly (not toggling) keeps the phase self-correcting.
          if (div_cnt == DIV_W'(DIVISOR - 1)) begin
            div_cnt_n = '0;
            cpu_clk_n = 1'b0;
          end else begin
            div_cnt_n = div_cnt + DIV_W'(1);
            if (half_done) cpu_clk_n = 1'b1;
          end
        end
      end
      STEP_HI: begin
        cpu_clk_n = 1'b1;
        div_cnt_n = div_cnt + DIV_W'(1);
        if (half_done) begin
          state_n   = STEP_LO;
          cpu_clk_n = 1'b0;
          div_cnt_n = '0;
        end
      end
      STEP_LO: begin
        cpu_clk_n = 1'b0;
        div_cnt_n = div_cnt + DIV_W'(1);
        if (half_done) begin
          state_n   = HALT;
          div_cnt_n = '0;
        end
      end
      default: begin
        state_n   = HALT;
        cpu_clk_n = 1'b0;
        div_cnt_n = '0;
      end
    endcase
  end

  // cpu_clk is a flop with async reset, so reset drops it immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= HALT;
      div_cnt  <= '0;
      cpu_clk  <= 1'b0;
      tick_cnt <= '0;
    end else begin
      state   <= state_n;
      div_cnt <= div_cnt_n;
      cpu_clk <= cpu_clk_n;
      // Count on the same edge that raises cpu_clk.
      if (cpu_clk_n && !cpu_clk) tick_cnt <= tick_cnt + 16'd1;
    end
  end

  // ---------------------------------------------------------------------------
  // Display page and digits
  // ---------------------------------------------------------------------------
  logic [1:0] page;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      page <= 2'd0;
    end else if (press[2]) begin
      page <= (page == 2'd2) ? 2'd0 : page + 2'd1;
    end
  end

  logic [31:0] sp_mod;
  logic [31:0] pc_mod;
  logic [15:0] digits;

  always_comb begin
    sp_mod = 32'(sp) % 32'd100;
    pc_mod = 32'(pc) % 32'd100;
    case (page)
      2'd0:    digits = {4'(sp_mod / 32'd10), 4'(sp_mod % 32'd10),
                         4'(pc_mod / 32'd10), 4'(pc_mod % 32'd10)};
      2'd1:    digits = cpu_out[15:0];
      default: digits = tick_cnt;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hex <= {4{ssd_seg(4'd0)}};
    end else begin
      hex <= {ssd_seg(digits[15:12]), ssd_seg(digits[11:8]),
              ssd_seg(digits[7:4]),   ssd_seg(digits[3:0])};
    end
  end

  assign led = {(state == RUN),
                (state == STEP_HI) || (state == STEP_LO),
                page,
                cpu_clk,
                cpu_out[4:0]};

endmodule

// File: tb/tb_cpu_debug_ctrl.sv
// -----------------------------------------------------------------------------
// Self-checking bench for cpu_debug_ctrl with DIVISOR=4, DEBOUNCE=3 and a
// 7-bit address so the modulo-100 display rule can be exercised.
// -----------------------------------------------------------------------------
module tb_cpu_debug_ctrl;

  localparam int DIVISOR  = 4;
  localparam int DEBOUNCE = 3;
  localparam int AW       = 7;
  localparam int DW       = 16;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [2:0]    btn = 3'b111;
  logic [AW-1:0] pc = '0;
  logic [AW-1:0] sp = '0;
  logic [DW-1:0] cpu_out = '0;
  logic          cpu_clk;
  logic [9:0]    led;
  logic [27:0]   hex;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  cpu_debug_ctrl #(
    .DIVISOR   (DIVISOR),
    .DEBOUNCE  (DEBOUNCE),
    .ADDR_WIDTH(AW),
    .DATA_WIDTH(DW)
  ) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .btn    (btn),
    .pc     (pc),
    .sp     (sp),
    .cpu_out(cpu_out),
    .cpu_clk(cpu_clk),
    .led    (led),
    .hex    (hex)
  );

  // Active-low segment patterns {g,f,e,d,c,b,a} for digits 0..F.
  logic [6:0] seg_tab [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12,
                               7'h02, 7'h78, 7'h00, 7'h10, 7'h08, 7'h03,
                               7'h46, 7'h21, 7'h06, 7'h0E};

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic check_range(input string name, input int act,
                             input int lo, input int hi);
    checks++;
    if (act < lo || act > hi) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d..%0d", name, act, lo, hi);
    end
  endtask

  // ---- reference model ------------------------------------------------------
  function automatic logic [27:0] enc(input logic [15:0] d);
    return {seg_tab[d[15:12]], seg_tab[d[11:8]], seg_tab[d[7:4]], seg_tab[d[3:0]]};
  endfunction

  function automatic logic [15:0] page0_digits(input int p, input int s);
    int sm, pm;
    sm = s % 100;
    pm = p % 100;
    return {4'(sm / 10), 4'(sm % 10), 4'(pm / 10), 4'(pm % 10)};
  endfunction

  // Bit 16 set when some digit is not a legal pattern.
  function automatic logic [16:0] decode_hex(input logic [27:0] h);
    logic [16:0] r;
    logic [6:0]  s;
    logic        found;
    r = '0;
    for (int d = 0; d < 4; d++) begin
      s = h[d*7 +: 7];
      found = 1'b0;
      for (int n = 0; n < 16; n++) begin
        if (seg_tab[n] == s) begin
          r[d*4 +: 4] = 4'(n);
          found = 1'b1;
        end
      end
      if (!found) r[16] = 1'b1;
    end
    return r;
  endfunction

  // ---- cpu_clk monitor, sampled 1 time unit after each rising clk ---------
  logic prev_cc = 1'b0;
  int   cyc = 0, rise_cnt = 0, high_cyc = 0, step_cyc = 0, run_cyc = 0;
  int   last_rise = -1, min_per = 1000, max_per = 0;
  int   cur_hw = 0, min_hw = 1000, max_hw = 0;

  always begin
    @(posedge clk);
    #1;
    if (cpu_clk && !prev_cc) begin
      rise_cnt++;
      if (last_rise >= 0) begin
        if (cyc - last_rise < min_per) min_per = cyc - last_rise;
        if (cyc - last_rise > max_per) max_per = cyc - last_rise;
      end
      last_rise = cyc;
    end
    if (cpu_clk) begin
      high_cyc++;
      cur_hw++;
    end else if (prev_cc) begin
      if (cur_hw < min_hw) min_hw = cur_hw;
      if (cur_hw > max_hw) max_hw = cur_hw;
      cur_hw = 0;
    end
    if (led[8]) step_cyc++;
    if (led[9]) run_cyc++;
    prev_cc = cpu_clk;
    cyc++;
  end

  // Called only at a falling clk edge.
  task automatic clear_mon();
    rise_cnt = 0; high_cyc = 0; step_cyc = 0; run_cyc = 0;
    last_rise = -1; min_per = 1000; max_per = 0;
    cur_hw = 0; min_hw = 1000; max_hw = 0;
    prev_cc = cpu_clk;
  endtask

  // Hold the masked buttons low for 'hold' clks, release, let release settle.
  task automatic press(input logic [2:0] mask, input int hold);
    btn = ~mask;
    repeat (hold) @(negedge clk);
    btn = 3'b111;
    repeat (8) @(negedge clk);
  endtask

  task automatic read_tick(output logic [15:0] t);
    logic [16:0] r;
    r = decode_hex(hex);
    check("tick_digits_legal", 32'(r[16]), 32'd0);
    t = r[15:0];
  endtask

  // ---- table of page-0 vectors ---------------------------------------------
  typedef struct {
    logic [AW-1:0] pc;
    logic [AW-1:0] sp;
    logic [DW-1:0] cpu_out;
    logic [15:0]   exp_digits;
  } vec_t;

  vec_t tbl [6];

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin : main
    logic [15:0] t0, t1;
    logic [27:0] prev_hex;
    int          n;

    tbl[0] = '{pc: 7'd37,  sp: 7'd5,   cpu_out: 16'hBEEF, exp_digits: 16'h0537};
    tbl[1] = '{pc: 7'd0,   sp: 7'd0,   cpu_out: 16'h0000, exp_digits: 16'h0000};
    tbl[2] = '{pc: 7'd127, sp: 7'd99,  cpu_out: 16'h1234, exp_digits: 16'h9927};
    tbl[3] = '{pc: 7'd100, sp: 7'd10,  cpu_out: 16'hFFFF, exp_digits: 16'h1000};
    tbl[4] = '{pc: 7'd63,  sp: 7'd63,  cpu_out: 16'h001F, exp_digits: 16'h6363};
    tbl[5] = '{pc: 7'd9,   sp: 7'd110, cpu_out: 16'h0010, exp_digits: 16'h1009};

    // ---- reset state ----
    repeat (3) @(negedge clk);
    check("rst_cpu_clk", 32'(cpu_clk), 32'd0);
    check("rst_led_state", 32'(led[9:8]), 32'd0);
    check("rst_led_page", 32'(led[7:6]), 32'd0);
    check("rst_hex", 32'(hex), 32'(enc(16'h0000)));
    rst_n = 1'b1;
    clear_mon();
    repeat (100) @(negedge clk);
    check("idle_cpu_clk_high", 32'(high_cyc), 32'd0);
    check("idle_led_state", 32'(led[9:8]), 32'd0);
    check("idle_hex", 32'(hex), 32'(enc(16'h0000)));

    // ---- page 0 table, including register latency ----
    for (int i = 0; i < 6; i++) begin
      prev_hex = hex;
      pc = tbl[i].pc;
      sp = tbl[i].sp;
      cpu_out = tbl[i].cpu_out;
      #1;
      check($sformatf("tbl%0d_led_low", i), 32'(led[4:0]), 32'(tbl[i].cpu_out[4:0]));
      check($sformatf("tbl%0d_hex_hold", i), 32'(hex), 32'(prev_hex));
      @(negedge clk);
      check($sformatf("tbl%0d_hex", i), 32'(hex), 32'(enc(tbl[i].exp_digits)));
    end
    pc = 7'd37;
    sp = 7'd5;

    // ---- single step ----
    clear_mon();
    press(3'b001, 10);
    repeat (10) @(negedge clk);
    check("step_rises", 32'(rise_cnt), 32'd1);
    check("step_high_cycles", 32'(high_cyc), 32'd2);
    check("step_led8_cycles", 32'(step_cyc), 32'd4);
    check("step_back_halt", 32'(led[9:8]), 32'd0);

    // ---- 2-clk glitch is rejected ----
    clear_mon();
    press(3'b001, 2);
    repeat (10) @(negedge clk);
    check("glitch_rises", 32'(rise_cnt), 32'd0);
    check("glitch_led8", 32'(step_cyc), 32'd0);

    // ---- page 1: cpu_out in hex ----
    cpu_out = 16'hBEEF;
    press(3'b100, 10);
    check("page1_led", 32'(led[7:6]), 32'd1);
    check("page1_beef", 32'(hex), 32'(enc(16'hBEEF)));
    for (int i = 0; i < 20; i++) begin
      cpu_out = 16'($urandom);
      pc = 7'($urandom);
      @(negedge clk);
      check("rand_page1_hex", 32'(hex), 32'(enc(cpu_out)));
      check("rand_led_low", 32'(led[4:0]), 32'(cpu_out[4:0]));
    end

    // ---- page 2: tick count after the single step ----
    press(3'b100, 10);
    check("page2_led", 32'(led[7:6]), 32'd2);
    read_tick(t0);
    check("tick_after_step", 32'(t0), 32'd1);

    // ---- RUN: period, duty, tick rate ----
    btn = 3'b101;
    n = 0;
    while (led[9] !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("run_entered", 32'(led[9]), 32'd1);
    clear_mon();
    repeat (10) @(negedge clk);
    btn = 3'b111;
    repeat (30) @(negedge clk);
    read_tick(t1);
    check_range("run_tick_delta", int'(t1 - t0), 9, 11);
    check_range("run_rises", rise_cnt, 9, 11);
    check("run_min_period", 32'(min_per), 32'd4);
    check("run_max_period", 32'(max_per), 32'd4);
    check("run_min_high", 32'(min_hw), 32'd2);
    check("run_max_high", 32'(max_hw), 32'd2);
    check("run_no_step", 32'(step_cyc), 32'd0);

    // ---- halt from RUN ----
    press(3'b010, 10);
    read_tick(t0);
    clear_mon();
    repeat (30) @(negedge clk);
    read_tick(t1);
    check("halt_cpu_clk_high", 32'(high_cyc), 32'd0);
    check("halt_tick_frozen", 32'(t1), 32'(t0));
    check("halt_led9", 32'(led[9]), 32'd0);

    // ---- step and run/halt accepted together: run wins ----
    clear_mon();
    press(3'b011, 10);
    check("both_run", 32'(led[9]), 32'd1);
    check("both_no_step", 32'(step_cyc), 32'd0);
    check_range("both_run_cycles", run_cyc, 1, 1000);
    press(3'b010, 10);
    check("both_halted", 32'(led[9:8]), 32'd0);

    // ---- back to page 0, random pc/sp against the model ----
    press(3'b100, 10);
    check("page0_wrap_led", 32'(led[7:6]), 32'd0);
    for (int i = 0; i < 30; i++) begin
      pc = 7'($urandom);
      sp = 7'($urandom);
      cpu_out = 16'($urandom);
      @(negedge clk);
      check("rand_page0_hex", 32'(hex), 32'(enc(page0_digits(int'(pc), int'(sp)))));
    end

    // ---- async reset while cpu_clk is high in RUN ----
    press(3'b100, 10);
    check("pre_reset_page1", 32'(led[7:6]), 32'd1);
    press(3'b010, 10);
    n = 0;
    while (cpu_clk !== 1'b1 && n < 10) begin
      @(negedge clk);
      n++;
    end
    check("pre_reset_cpu_clk_high", 32'(cpu_clk), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst_cpu_clk", 32'(cpu_clk), 32'd0);
    check("async_rst_led_state", 32'(led[9:8]), 32'd0);
    check("async_rst_page", 32'(led[7:6]), 32'd0);
    check("async_rst_hex", 32'(hex), 32'(enc(16'h0000)));
    @(negedge clk);
    rst_n = 1'b1;
    clear_mon();
    repeat (20) @(negedge clk);
    check("post_rst_cpu_clk_high", 32'(high_cyc), 32'd0);
    check("post_rst_halt", 32'(led[9:8]), 32'd0);
    press(3'b100, 10);
    press(3'b100, 10);
    check("post_rst_page2", 32'(led[7:6]), 32'd2);
    read_tick(t0);
    check("post_rst_tick", 32'(t0), 32'd0);
    check("post_rst_still_halt", 32'(high_cyc), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
